dm_wait_resp: RTL and testbench

- Data-memory responder for the CPU's data bus, with a req/ready handshake.
- A request is accepted, held for a programmable number of wait states, then completed with a one-cycle ready pulse.
- Supports word/half/byte stores and sign- or zero-extended loads, little-endian.
- Sits between the CPU load/store path and byte-organised data RAM. It is the multi-cycle replacement for the zero-latency data memory, so stall logic can be exercised.

---
 rtl/dm_wait_resp.sv | 195 +++++++++++++++++++
 tb/tb_dm_wait_resp.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_wait_resp.sv
// dm_wait_resp: data-memory responder with programmable wait states.
// A request accepted in IDLE is held for WAIT_CYCLES cycles and then completed
// with a one-cycle ready pulse. Stores commit and loads read the RAM on the
// edge that enters RESP. Little-endian, word/half/byte access.
// Optional macro DM_MISALIGN_CHECK_EN: misaligned half/word accesses complete
// with err=1, dout=0 and no RAM write. Without it err is always 0.
//
// Handshake: req is sampled only in IDLE. The accepted operation is completed
// by ready=1 for exactly one cycle; the requester must drop req in that cycle,
// because req still high in the following IDLE cycle starts a new request.
module dm_wait_resp #(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       din,
    input  logic [1:0]        whb,
    input  logic              lsign,
    output logic              ready,
    output logic [31:0]       dout,
    output logic              busy,
    output logic              err,
    output logic [1:0]        dbg_state
);

    localparam int DEPTH = 1 << (ADDR_W - 2);
    localparam int WAIT_INIT_I = (WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_INIT_I);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              ready_q;
    logic [31:0]       dout_q;
    logic              busy_q;
    logic              err_q;

    // Captured request
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       din_q;
    logic [1:0]        whb_q;
    logic              lsign_q;

    logic [31:0]       mem [0:DEPTH-1];

    // Operation currently being handled: live inputs while in IDLE (needed
    // when WAIT_CYCLES=0 and RESP is entered straight from IDLE), otherwise
    // the captured copy.
    logic              op_we;
    logic [ADDR_W-1:0] op_addr;
    logic [31:0]       op_din;
    logic [1:0]        op_whb;
    logic              op_lsign;
    logic [ADDR_W-3:0] op_widx;
    logic              op_half;
    logic              op_byte;
    logic              op_mis;
    logic              enter_resp;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;
    logic [31:0]       rd_word;
    logic [15:0]       rd_half;
    logic [7:0]        rd_byte;
    logic [31:0]       ld_val;

    // Select the active operation and decode size, alignment and byte lanes
    always_comb begin
        op_we    = we_q;
        op_addr  = addr_q;
        op_din   = din_q;
        op_whb   = whb_q;
        op_lsign = lsign_q;
        if (state_q == S_IDLE) begin
            op_we    = we;
            op_addr  = address;
            op_din   = din;
            op_whb   = whb;
            op_lsign = lsign;
        end
        op_widx = op_addr[ADDR_W-1:2];
        op_half = (op_whb == 2'b01);
        op_byte = (op_whb == 2'b10);
`ifdef DM_MISALIGN_CHECK_EN
        op_mis = (op_half && op_addr[0]) ||
                 (!op_half && !op_byte && (op_addr[1:0] != 2'b00));
`else
        op_mis = 1'b0;
`endif
        enter_resp = ((state_q == S_IDLE) && req && (WAIT_CYCLES == 0)) ||
                     ((state_q == S_WAIT) && (cnt_q == 4'd0));

        wr_be   = 4'b1111;
        wr_data = op_din;
        if (op_half) begin
            wr_be   = op_addr[1] ? 4'b1100 : 4'b0011;
            wr_data = {op_din[15:0], op_din[15:0]};
        end else if (op_byte) begin
            wr_be   = 4'b0001 << op_addr[1:0];
            wr_data = {4{op_din[7:0]}};
        end

        rd_word = mem[op_widx];
        rd_half = op_addr[1] ? rd_word[31:16] : rd_word[15:0];
        rd_byte = rd_word[8*op_addr[1:0] +: 8];
        ld_val  = rd_word;
        if (op_half) begin
            ld_val = {{16{op_lsign & rd_half[15]}}, rd_half};
        end else if (op_byte) begin
            ld_val = {{24{op_lsign & rd_byte[7]}}, rd_byte};
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            dout_q  <= 32'd0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= 32'd0;
            whb_q   <= 2'b00;
            lsign_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            dout_q  <= 32'd0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= address;
                        din_q   <= din;
                        whb_q   <= whb;
                        lsign_q <= lsign;
                        busy_q  <= 1'b1;
                        cnt_q   <= WAIT_INIT;
                        state_q <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
            if (enter_resp) begin
                ready_q <= 1'b1;
                err_q   <= op_mis;
                dout_q  <= (op_we || op_mis) ? 32'd0 : ld_val;
            end
        end
    end

    // Store commit on the edge entering RESP; a reset on that edge aborts it
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && op_we && !op_mis) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[op_widx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign ready     = ready_q;
    assign dout      = dout_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dm_wait_resp.sv
// tb_dm_wait_resp: directed vector table, multi-cycle corner sequences and
// randomized traffic checked against a byte-array reference model.
module tb_dm_wait_resp;

    localparam int AW = 9;
    localparam int WC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [AW-1:0] address;
    logic [31:0] din;
    logic [1:0]  whb;
    logic        lsign;
    logic        ready;
    logic [31:0] dout;
    logic        busy;
    logic        err;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] ref_mem [0:(1<<AW)-1];

    typedef struct {
        logic        w;
        logic [8:0]  a;
        logic [31:0] d;
        logic [1:0]  sz;
        logic        ls;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    vec_t vecs [12];

    dm_wait_resp #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .address(address),
        .din(din), .whb(whb), .lsign(lsign), .ready(ready), .dout(dout),
        .busy(busy), .err(err), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    // Reference model: little-endian byte array, sizes from the access rules
    function automatic void model_op(input logic w, input logic [8:0] a,
                                     input logic [31:0] di, input logic [1:0] sz,
                                     input logic ls, output logic [31:0] ed,
                                     output logic ee);
        int n;
        int base;
        logic mis;
        logic [31:0] v;
        n = (sz == 2'b01) ? 2 : (sz == 2'b10) ? 1 : 4;
        mis = 1'b0;
`ifdef DM_MISALIGN_CHECK_EN
        mis = ((n == 2) && a[0]) || ((n == 4) && (a[1:0] != 2'b00));
`endif
        base = int'(a) - (int'(a) % n);
        ee = mis;
        ed = 32'd0;
        if (mis) return;
        if (w) begin
            for (int i = 0; i < n; i++) ref_mem[base + i] = di[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[base + i];
            if (ls && (n < 4) && v[8*n-1]) begin
                for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
            end
            ed = v;
        end
    endfunction

    // Driver: one transaction, req dropped right after accept and the other
    // inputs scrambled to show they are ignored once captured.
    task automatic do_txn(input logic w, input logic [8:0] a, input logic [31:0] d,
                          input logic [1:0] sz, input logic ls,
                          output logic [31:0] got_d, output logic got_e);
        int lat;
        logic busy_ok;
        @(negedge clk);
        req = 1'b1; we = w; address = a; din = d; whb = sz; lsign = ls;
        lat = -1;
        busy_ok = 1'b1;
        got_d = 32'd0;
        got_e = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req = 1'b0;
                we = 1'($urandom_range(0, 1));
                address = 9'($urandom_range(0, 511));
                din = $urandom;
                whb = 2'($urandom_range(0, 3));
                lsign = 1'($urandom_range(0, 1));
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (ready === 1'b1) begin
                lat = c;
                got_d = dout;
                got_e = err;
                break;
            end
        end
        chk("latency", 32'(lat), 32'(WC + 1));
        chk("busy_during", {31'd0, busy_ok}, 32'd1);
        @(negedge clk);
        chk("post_ready", {31'd0, ready}, 32'd0);
        chk("post_dout", dout, 32'd0);
        chk("post_busy", {31'd0, busy}, 32'd0);
    endtask

    // Request held a number of cycles past the first ready; counts pulses
    task automatic held_req(input int extra, output int pulses, output int first);
        @(negedge clk);
        req = 1'b1; we = 1'b0; address = 9'h010; din = 32'd0; whb = 2'b00; lsign = 1'b0;
        pulses = 0;
        first = -1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                pulses++;
                if (first < 0) first = c;
            end
            if ((first >= 0) && (c == first + extra)) req = 1'b0;
        end
        req = 1'b0;
    endtask

    // Store aborted by a reset asserted rst_at cycles after accept
    task automatic reset_in_wait(input int rst_at);
        int seen;
        @(negedge clk);
        req = 1'b1; we = 1'b1; address = 9'h030; din = 32'h12345678; whb = 2'b00; lsign = 1'b0;
        seen = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) req = 1'b0;
            if (c == rst_at) rst = 1'b1;
            if (c == rst_at + 1) rst = 1'b0;
            if (ready === 1'b1) seen++;
        end
        chk("rst_wait_no_ready", 32'(seen), 32'd0);
        chk("rst_wait_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] gd;
        logic        ge;
        logic [31:0] ed;
        logic        ee;
        int          pulses;
        int          first;

        rst = 1'b1; req = 1'b0; we = 1'b0; address = '0; din = 32'd0; whb = 2'b00; lsign = 1'b0;

        // Directed vectors
        vecs[0]  = '{1'b1, 9'h010, 32'hDEADBEEF, 2'b00, 1'b0, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 9'h010, 32'h00000000, 2'b00, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 9'h020, 32'h00000000, 2'b00, 1'b0, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b1, 9'h021, 32'h00000080, 2'b10, 1'b0, 32'h00000000, 1'b0};
        vecs[4]  = '{1'b1, 9'h022, 32'h0000F00D, 2'b01, 1'b0, 32'h00000000, 1'b0};
        vecs[5]  = '{1'b0, 9'h020, 32'h00000000, 2'b00, 1'b1, 32'hF00D8000, 1'b0};
        vecs[6]  = '{1'b0, 9'h021, 32'h00000000, 2'b10, 1'b1, 32'hFFFFFF80, 1'b0};
        vecs[7]  = '{1'b0, 9'h021, 32'h00000000, 2'b10, 1'b0, 32'h00000080, 1'b0};
        vecs[8]  = '{1'b0, 9'h022, 32'h00000000, 2'b01, 1'b1, 32'hFFFFF00D, 1'b0};
        vecs[9]  = '{1'b0, 9'h022, 32'h00000000, 2'b01, 1'b0, 32'h0000F00D, 1'b0};
`ifdef DM_MISALIGN_CHECK_EN
        vecs[10] = '{1'b1, 9'h033, 32'hCAFEF00D, 2'b00, 1'b0, 32'h00000000, 1'b1};
        vecs[11] = '{1'b0, 9'h030, 32'h00000000, 2'b00, 1'b0, 32'hA5A5A5A5, 1'b0};
`else
        vecs[10] = '{1'b1, 9'h033, 32'hCAFEF00D, 2'b00, 1'b0, 32'h00000000, 1'b0};
        vecs[11] = '{1'b0, 9'h030, 32'h00000000, 2'b00, 1'b0, 32'hCAFEF00D, 1'b0};
`endif

        // Reset then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_ready", {31'd0, ready}, 32'd0);
            chk("idle_busy", {31'd0, busy}, 32'd0);
            chk("idle_dout", dout, 32'd0);
            chk("idle_err", {31'd0, err}, 32'd0);
        end

        // Reset in WAIT: old value survives both abort points
        do_txn(1'b1, 9'h030, 32'hA5A5A5A5, 2'b00, 1'b0, gd, ge);
        reset_in_wait(1);
        reset_in_wait(2);
        do_txn(1'b0, 9'h030, 32'd0, 2'b00, 1'b0, gd, ge);
        chk("rst_wait_old_value", gd, 32'hA5A5A5A5);

        // Table
        for (int i = 0; i < 12; i++) begin
            do_txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].sz, vecs[i].ls, gd, ge);
            chk($sformatf("vec%0d_dout", i), gd, vecs[i].exp_d);
            chk($sformatf("vec%0d_err", i), {31'd0, ge}, {31'd0, vecs[i].exp_e});
        end

        // Held req: dropped in ready cycle, then held one cycle past ready
        held_req(0, pulses, first);
        chk("held0_pulses", 32'(pulses), 32'd1);
        chk("held0_first", 32'(first), 32'(WC + 1));
        repeat (2) @(negedge clk);
        held_req(2, pulses, first);
        chk("held2_pulses", 32'(pulses), 32'd2);
        repeat (2) @(negedge clk);

        // Random traffic in the upper half, seeded with known words
        for (int wi = 64; wi < 128; wi++) begin
            logic [31:0] rv;
            rv = $urandom;
            model_op(1'b1, 9'(wi * 4), rv, 2'b00, 1'b0, ed, ee);
            do_txn(1'b1, 9'(wi * 4), rv, 2'b00, 1'b0, gd, ge);
        end
        for (int k = 0; k < 250; k++) begin
            logic        rw;
            logic [8:0]  ra;
            logic [31:0] rd;
            logic [1:0]  rs;
            logic        rl;
            rw = 1'($urandom_range(0, 1));
            ra = 9'($urandom_range(256, 511));
            rd = $urandom;
            rs = 2'($urandom_range(0, 3));
            rl = 1'($urandom_range(0, 1));
            model_op(rw, ra, rd, rs, rl, ed, ee);
            do_txn(rw, ra, rd, rs, rl, gd, ge);
            chk($sformatf("rand%0d_dout", k), gd, ed);
            chk($sformatf("rand%0d_err", k), {31'd0, ge}, {31'd0, ee});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
